// File: rtl/iter_multiplier_pkg.sv
// Shared codes for the iterative multiplier: accumulate modes and FSM states.
package iter_multiplier_pkg;

    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_ADD  = 2'b01;
    localparam logic [1:0] ACC_SUB  = 2'b10;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'b00,
        MULT_CALC = 2'b01,
        MULT_FIX  = 2'b10
    } mult_state_e;

endpackage

// File: rtl/iter_multiplier_mult_step.sv
// One shift-add iteration: adds BITS_PER_CYCLE partial products to the running product.
// Combinational, zero latency; no flow control.
module iter_multiplier_mult_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [2*WIDTH-1:0]        prod_i,
    input  logic [2*WIDTH-1:0]        mcand_i,
    input  logic [BITS_PER_CYCLE-1:0] bits_i,
    output logic [2*WIDTH-1:0]        prod_o
);

    always_comb begin
        prod_o = prod_i;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (bits_i[i]) begin
                prod_o = prod_o + (mcand_i << i);
            end
        end
    end

endmodule

// File: rtl/iter_multiplier.sv
// Multi-cycle shift-add multiplier with sign fix-up and HI/LO accumulate.
// Latency WIDTH/BITS_PER_CYCLE + 2 cycles to done; start ignored while busy, cancel aborts.
module iter_multiplier
    import iter_multiplier_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cancel,
    input  logic                 signed_op,
    input  logic [1:0]           acc_mode,
    input  logic [WIDTH-1:0]     operand_1,
    input  logic [WIDTH-1:0]     operand_2,
    input  logic [2*WIDTH-1:0]   acc_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int PW    = 2 * WIDTH;
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_cfg
            $error("iter_multiplier: WIDTH must be a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    mult_state_e        state_q;
    logic [PW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [PW-1:0]      prod_q;
    logic [PW-1:0]      prod_d;
    logic [PW-1:0]      acc_q;
    logic [1:0]         acc_mode_q;
    logic               neg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [PW-1:0]      result_q;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [PW-1:0]      fixed_p;
    logic [PW-1:0]      result_d;

    // Negating the most negative value wraps back to itself, which read unsigned is exactly 2^(W-1).
    assign mag1 = (signed_op && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
    assign mag2 = (signed_op && operand_2[WIDTH-1]) ? -operand_2 : operand_2;

    always_comb begin
        fixed_p = neg_q ? -prod_q : prod_q;
        case (acc_mode_q)
            ACC_NONE: result_d = fixed_p;
            ACC_ADD:  result_d = acc_q + fixed_p;
            ACC_SUB:  result_d = acc_q - fixed_p;
            default:  result_d = fixed_p;
        endcase
    end

    iter_multiplier_mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .prod_i  (prod_q),
        .mcand_i (mcand_q),
        .bits_i  (mplier_q[BITS_PER_CYCLE-1:0]),
        .prod_o  (prod_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= MULT_IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            acc_mode_q <= ACC_NONE;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MULT_IDLE: begin
                    if (start && !cancel) begin
                        state_q    <= MULT_CALC;
                        busy_q     <= 1'b1;
                        mcand_q    <= {{WIDTH{1'b0}}, mag1};
                        mplier_q   <= mag2;
                        neg_q      <= signed_op & (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
                        acc_mode_q <= acc_mode;
                        acc_q      <= acc_in;
                        prod_q     <= '0;
                        cnt_q      <= '0;
                    end
                end
                MULT_CALC: begin
                    if (cancel) begin
                        state_q <= MULT_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        prod_q   <= prod_d;
                        mcand_q  <= mcand_q << BITS_PER_CYCLE;
                        mplier_q <= mplier_q >> BITS_PER_CYCLE;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == LAST_STEP) begin
                            state_q <= MULT_FIX;
                        end
                    end
                end
                MULT_FIX: begin
                    state_q <= MULT_IDLE;
                    busy_q  <= 1'b0;
                    if (!cancel) begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= MULT_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Directed-vector bench for iter_multiplier at default and 16-bit/radix-16 configurations.
module tb_iter_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic        signed_op = 1'b0;
    logic [1:0]  acc_mode = 2'b00;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic [63:0] acc_in = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;

    logic        start16 = 1'b0;
    logic        cancel16 = 1'b0;
    logic        signed16 = 1'b0;
    logic [1:0]  mode16 = 2'b00;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [31:0] acc16 = '0;
    logic        busy16;
    logic        done16;
    logic [31:0] result16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iter_multiplier u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cancel    (cancel),
        .signed_op (signed_op),
        .acc_mode  (acc_mode),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .acc_in    (acc_in),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    iter_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start16),
        .cancel    (cancel16),
        .signed_op (signed16),
        .acc_mode  (mode16),
        .operand_1 (a16),
        .operand_2 (b16),
        .acc_in    (acc16),
        .busy      (busy16),
        .done      (done16),
        .result    (result16)
    );

    typedef struct {
        bit          s;
        logic [1:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] acc;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one 32-bit op; operands are scrambled right after acceptance.
    task automatic do_op(input vec_t v, output logic [63:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        signed_op = v.s; acc_mode = v.m; operand_1 = v.a; operand_2 = v.b; acc_in = v.acc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        operand_1 = ~v.a; operand_2 = v.b ^ 32'h5A5A_A5A5; acc_in = ~v.acc; acc_mode = ~v.m; signed_op = ~v.s;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_ok = 1'b0;
        res = result;
    endtask

    function automatic logic [31:0] model16(input bit s, input logic [1:0] m, input logic [15:0] a,
                                            input logic [15:0] b, input logic [31:0] acc);
        longint sa, sb, p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        case (m)
            2'b01:   return acc + p[31:0];
            2'b10:   return acc - p[31:0];
            default: return p[31:0];
        endcase
    endfunction

    initial begin
        logic [63:0] res;
        int          lat;
        bit          bok;
        int          dcount;
        int          dcyc[$];
        logic [63:0] dres[$];
        bit          seen;

        vecs[0]  = '{1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0005, 64'h0, 64'hFFFF_FFFF_FFFF_FFFB};
        vecs[2]  = '{1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000};
        vecs[3]  = '{1'b1, 2'b01, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000};
        vecs[4]  = '{1'b1, 2'b10, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 64'h0};
        vecs[5]  = '{1'b0, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000};
        vecs[6]  = '{1'b1, 2'b00, 32'h8000_0000, 32'h0000_0001, 64'h0, 64'hFFFF_FFFF_8000_0000};
        vecs[7]  = '{1'b1, 2'b11, 32'h0000_0003, 32'hFFFF_FFFE, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[8]  = '{1'b1, 2'b10, 32'h0000_0002, 32'h0000_0003, 64'h0, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[9]  = '{1'b0, 2'b01, 32'h0000_0001, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[10] = '{1'b1, 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 64'h0, 64'hC000_0000_8000_0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_result", result, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            do_op(vecs[i], res, lat, bok);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd18);
            check($sformatf("vec%0d_busy", i), {63'h0, bok}, 64'h1);
        end
        @(posedge clk); #1;
        check("done_one_pulse", {63'h0, done}, 64'h0);

        // Cancel at CALC cycle 5: busy drops, no done, result holds
        @(negedge clk);
        signed_op = 1'b0; acc_mode = 2'b00; operand_1 = 32'h1234_5678; operand_2 = 32'h9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_busy", {63'h0, busy}, 64'h0);
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("cancel_no_done", {63'h0, seen}, 64'h0);
        check("cancel_result_held", result, vecs[10].exp);

        // Start together with cancel in IDLE is dropped
        @(negedge clk);
        start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_busy", {63'h0, busy}, 64'h0);
        seen = 1'b0;
        repeat (22) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("start_cancel_no_done", {63'h0, seen}, 64'h0);

        // Start held high: back-to-back acceptance, operands changed during busy
        @(negedge clk);
        signed_op = 1'b0; acc_mode = 2'b00; operand_1 = 32'h0000_0007; operand_2 = 32'h0000_0006; start = 1'b1;
        @(posedge clk); #1;
        operand_1 = 32'h0000_0100; operand_2 = 32'h0000_0003;
        for (int c = 1; c <= 60; c++) begin
            if (c == 36) start = 1'b0;
            if (done) begin
                dcyc.push_back(c);
                dres.push_back(result);
            end
            @(posedge clk); #1;
        end
        dcount = dcyc.size();
        check("b2b_done_count", 64'(dcount), 64'd2);
        if (dcount == 2) begin
            check("b2b_gap", 64'(dcyc[1] - dcyc[0]), 64'd18);
            check("b2b_first_result", dres[0], 64'd42);
            check("b2b_second_result", dres[1], 64'h300);
        end

        // Reset mid-operation at CALC cycle 3
        @(negedge clk);
        operand_1 = 32'hFFFF_FFFF; operand_2 = 32'h2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_done", {63'h0, done}, 64'h0);
        check("midrst_result", result, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // 16-bit, 4 bits per cycle: random sweep against the reference model
        for (int k = 0; k < 24; k++) begin
            logic [31:0] exp16;
            int          l16;
            @(negedge clk);
            signed16 = 1'($urandom_range(0, 1));
            mode16   = 2'($urandom_range(0, 3));
            a16      = (k == 0) ? 16'h8000 : 16'($urandom);
            b16      = (k == 0) ? 16'h8000 : 16'($urandom);
            acc16    = $urandom;
            exp16    = model16(signed16, mode16, a16, b16, acc16);
            start16  = 1'b1;
            @(posedge clk); #1;
            start16 = 1'b0;
            l16 = 1;
            while (!done16 && l16 < 50) begin
                @(posedge clk); #1;
                l16++;
            end
            check($sformatf("w16_%0d_result", k), {32'h0, result16}, {32'h0, exp16});
            if (k == 0) check("w16_latency", 64'(l16), 64'd6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
